dma_priority_arbiter: RTL
=========================

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on posedge CLK.
REQ-002 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port DREQ, input, 4 bits: per-channel hardware DMA requests; asserted level set by dreqSense.
REQ-004 SHALL have port swRequest, input, 4 bits: software request register bits; active-high; bypass the mask.
REQ-005 SHALL have port maskReg, input, 4 bits: 1 = channel hardware request masked.
REQ-006 SHALL have port ctrlDisable, input, 1 bit: 1 = controller disabled; no new requests accepted.
REQ-007 SHALL have port priorityType, input, 1 bit: 0 = fixed priority (ch0 highest), 1 = rotating priority.
REQ-008 SHALL have port dreqSense, input, 1 bit: 1 = DREQ active-high, 0 = DREQ active-low.
REQ-009 SHALL have port dackSense, input, 1 bit: 1 = DACK active-high, 0 = DACK active-low.
REQ-010 SHALL have port HLDA, input, 1 bit: hold acknowledge from the CPU.
REQ-011 SHALL have port transferDone, input, 1 bit: one-cycle pulse from timing/control at the end of the granted service (S4 / terminal count).
REQ-012 SHALL have port HRQ, output, 1 bit: hold request to the CPU; registered.
REQ-013 SHALL have port DACK, output, 4 bits: per-channel acknowledge; polarity per dackSense.
REQ-014 SHALL have port activeChannel, output, 2 bits: encoded index of the granted channel.
REQ-015 SHALL have port assertDACK, output, 1 bit: 1 while a grant is held; drives timing/control start.
REQ-016 SHALL have port abortPulse, output, 1 bit: one-cycle pulse when HLDA drops during a grant.

Function
REQ-017 SHALL compute the effective request per channel as eff[i] = ((DREQ[i] == dreqSense) AND NOT maskReg[i]) OR swRequest[i], combinationally from the current inputs.
REQ-018 SHALL implement the one-hot states IDLE, WAIT_HLDA, GRANT and RELEASE.
REQ-019 IDLE: if eff != 0 and ctrlDisable = 0, SHALL go to WAIT_HLDA and set HRQ = 1 at the same edge; otherwise SHALL stay in IDLE with HRQ = 0.
REQ-020 WAIT_HLDA: SHALL hold HRQ = 1; on an edge with HLDA = 1 and eff != 0, SHALL latch the winner, go to GRANT, and assert DACK/assertDACK from that edge.
REQ-021 WAIT_HLDA: if eff = 0 (request withdrawn), SHALL go to IDLE and clear HRQ, regardless of HLDA.
REQ-022 Winner selection, priorityType = 0: SHALL pick the lowest-index set eff bit.
REQ-023 Winner selection, priorityType = 1: SHALL scan from channel (lowPri+1) mod 4 upward with wrap-around and pick the first set bit.
REQ-024 GRANT: SHALL keep the winner fixed with no preemption; changes in eff or maskReg during GRANT SHALL be ignored.
REQ-025 GRANT: DACK SHALL be the one-hot of activeChannel, XOR-inverted when dackSense = 0; non-granted bits SHALL be inactive.
REQ-026 GRANT with transferDone = 1: SHALL go to RELEASE, clear HRQ, DACK and assertDACK, and set lowPri = activeChannel.
REQ-027 GRANT with HLDA = 0 and transferDone = 0: SHALL go to IDLE, clear HRQ and DACK, pulse abortPulse for one cycle, and leave lowPri unchanged.
REQ-028 GRANT with transferDone = 1 and HLDA = 0 on the same edge: transferDone SHALL win (REQ-026 applies; no abort).
REQ-029 RELEASE: SHALL last exactly one cycle with HRQ = 0, then go to IDLE; a new request SHALL therefore raise HRQ no earlier than 2 edges after transferDone.
REQ-030 ctrlDisable = 1 SHALL NOT terminate a grant in progress; it only blocks the IDLE -> WAIT_HLDA transition.
REQ-031 Two or more simultaneous requests SHALL resolve per REQ-022/023 on the HLDA edge, not on the edge where HRQ was raised.
REQ-032 Outputs HRQ, the one-hot grant, activeChannel, assertDACK and abortPulse SHALL all be registered; DACK polarity inversion MAY be combinational.

Reset
REQ-033 RESET = 1 SHALL immediately force: state = IDLE, HRQ = 0, grant one-hot = 0 (DACK = 4'b0000 if dackSense = 1, 4'b1111 if 0), activeChannel = 0, assertDACK = 0, abortPulse = 0, lowPri = 3.
REQ-034 RESET asserted mid-GRANT SHALL drop the grant with no abortPulse; the first request after RESET deasserts SHALL raise HRQ at the next edge.

Verification
REQ-035 Fixed priority: dreqSense = 1, DREQ = 4'b0011, HLDA = 1 -> HRQ at edge 1, DACK = 4'b0001 at edge 2, activeChannel = 0.
REQ-036 Rotating priority: priorityType = 1, DREQ = 4'b0011 held, two grants each ended by transferDone -> first grant ch0, second grant ch1, lowPri = 1.
REQ-037 Mask/software request: maskReg = 4'b0001, DREQ = 4'b0001, swRequest = 4'b0100 -> DACK = 4'b0100.
REQ-038 Abort: in GRANT ch2, HLDA -> 0 -> IDLE next edge, DACK = 0, abortPulse = 1 for one cycle, lowPri unchanged (3).
REQ-039 Withdrawal/polarity: dackSense = 0, DREQ asserted then withdrawn before HLDA -> HRQ drops, DACK stays 4'b1111.
REQ-040 Async reset mid-grant: RESET pulsed between clock edges in GRANT -> HRQ = 0 and DACK inactive before the next CLK edge.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// rtl/dma_priority_arbiter_if.sv - request/grant bundle between DMA timing logic and the priority arbiter
interface dma_priority_arbiter_if;
    logic [3:0] DREQ;
    logic [3:0] swRequest;
    logic [3:0] maskReg;
    logic       ctrlDisable;
    logic       priorityType;
    logic       dreqSense;
    logic       dackSense;
    logic       HLDA;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       assertDACK;
    logic       abortPulse;

    modport master (
        output DREQ, swRequest, maskReg, ctrlDisable, priorityType,
        output dreqSense, dackSense, HLDA, transferDone,
        input  HRQ, DACK, activeChannel, assertDACK, abortPulse
    );

    modport slave (
        input  DREQ, swRequest, maskReg, ctrlDisable, priorityType,
        input  dreqSense, dackSense, HLDA, transferDone,
        output HRQ, DACK, activeChannel, assertDACK, abortPulse
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - four-channel DMA request arbiter with fixed or rotating priority
module dma_priority_arbiter (
    input  logic                   CLK,
    input  logic                   RESET,
    dma_priority_arbiter_if.slave  bus
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_WAIT_HLDA = 4'b0010,
        ST_GRANT     = 4'b0100,
        ST_RELEASE   = 4'b1000
    } state_t;

    state_t     state_q;
    logic       hrq_q;
    logic [3:0] grant_q;
    logic [1:0] active_q;
    logic       assert_q;
    logic       abort_q;
    logic [1:0] lowpri_q;

    logic [3:0] eff_d;
    logic [1:0] winner_d;
    logic [1:0] scan_start_d;
    logic [1:0] scan_idx_d;

    // Effective request: hardware DREQ at its configured level and unmasked, or a software request
    always_comb begin
        eff_d = ((bus.DREQ ^ {4{~bus.dreqSense}}) & ~bus.maskReg) | bus.swRequest;
    end

    // Winner search: scan four slots from the start channel, the first set bit wins
    // (descending loop so the lowest scan offset is assigned last)
    always_comb begin
        winner_d     = 2'd0;
        scan_idx_d   = 2'd0;
        scan_start_d = bus.priorityType ? (lowpri_q + 2'd1) : 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx_d = scan_start_d + k[1:0];
            if (eff_d[scan_idx_d]) begin
                winner_d = scan_idx_d;
            end
        end
    end

    // Arbitration FSM; every output is a register written here
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            hrq_q    <= 1'b0;
            grant_q  <= 4'b0000;
            active_q <= 2'd0;
            assert_q <= 1'b0;
            abort_q  <= 1'b0;
            lowpri_q <= 2'd3;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((eff_d != 4'b0000) && !bus.ctrlDisable) begin
                        state_q <= ST_WAIT_HLDA;
                        hrq_q   <= 1'b1;
                    end else begin
                        hrq_q   <= 1'b0;
                    end
                end
                ST_WAIT_HLDA: begin
                    // Withdrawal beats HLDA; the winner is chosen on the HLDA edge, not earlier
                    if (eff_d == 4'b0000) begin
                        state_q <= ST_IDLE;
                        hrq_q   <= 1'b0;
                    end else if (bus.HLDA) begin
                        state_q  <= ST_GRANT;
                        grant_q  <= 4'b0001 << winner_d;
                        active_q <= winner_d;
                        assert_q <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // No preemption: only transferDone or loss of HLDA ends a grant;
                    // transferDone takes precedence when both arrive together
                    if (bus.transferDone) begin
                        state_q  <= ST_RELEASE;
                        hrq_q    <= 1'b0;
                        grant_q  <= 4'b0000;
                        assert_q <= 1'b0;
                        lowpri_q <= active_q;
                    end else if (!bus.HLDA) begin
                        state_q  <= ST_IDLE;
                        hrq_q    <= 1'b0;
                        grant_q  <= 4'b0000;
                        assert_q <= 1'b0;
                        abort_q  <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    hrq_q   <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    hrq_q    <= 1'b0;
                    grant_q  <= 4'b0000;
                    assert_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = grant_q ^ {4{~bus.dackSense}};
    assign bus.activeChannel = active_q;
    assign bus.assertDACK    = assert_q;
    assign bus.abortPulse    = abort_q;

endmodule
